// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key 2-FF sync, debounce, press/release pulses
// and typematic auto-repeat. Raw keys are active-low; all outputs active-high.
module key_conditioner #(
   parameter int N_KEYS        = 4,
   parameter int DEBOUNCE_CYC  = 1_000_000,
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000,
   parameter int CNT_W         = 26
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_KEYS-1:0] Key,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_repeat
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      RPT   = 2'd2
   } rpt_state_t;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

   genvar gi;
   generate
      for (gi = 0; gi < N_KEYS; gi++) begin : g_key
         logic             sync1_reg, sync2_reg;
         logic             pressed;
         logic [CNT_W-1:0] dcnt_reg, dcnt_next;
         logic             level_reg, level_next;
         logic             press_reg, press_next;
         logic             release_reg, release_next;
         logic             repeat_reg, repeat_next;
         rpt_state_t       state_reg, state_next;
         logic [CNT_W-1:0] rcnt_reg, rcnt_next;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               sync1_reg <= 1'b1;
               sync2_reg <= 1'b1;
            end else begin
               sync1_reg <= Key[gi];
               sync2_reg <= sync1_reg;
            end
         end

         assign pressed = ~sync2_reg;

         // Any sample agreeing with the accepted level discards the run so far.
         always_comb begin
            dcnt_next    = '0;
            level_next   = level_reg;
            press_next   = 1'b0;
            release_next = 1'b0;
            if (pressed != level_reg) begin
               if (dcnt_reg == DEB_LAST) begin
                  level_next   = pressed;
                  press_next   = pressed;
                  release_next = ~pressed;
               end else begin
                  dcnt_next = dcnt_reg + 1'b1;
               end
            end
         end

         // Keyed off level_next so a release in the same cycle as an expiry wins.
         always_comb begin
            state_next  = state_reg;
            rcnt_next   = rcnt_reg + 1'b1;
            repeat_next = 1'b0;
            if (!level_next) begin
               state_next = IDLE;
               rcnt_next  = '0;
            end else begin
               case (state_reg)
                  IDLE: begin
                     rcnt_next = '0;
                     if (press_next) state_next = DELAY;
                  end
                  DELAY: begin
                     if (rcnt_reg == RD_LAST) begin
                        repeat_next = 1'b1;
                        state_next  = RPT;
                        rcnt_next   = '0;
                     end
                  end
                  RPT: begin
                     if (rcnt_reg == RP_LAST) begin
                        repeat_next = 1'b1;
                        rcnt_next   = '0;
                     end
                  end
                  default: begin
                     state_next = IDLE;
                     rcnt_next  = '0;
                  end
               endcase
            end
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               dcnt_reg    <= '0;
               level_reg   <= 1'b0;
               press_reg   <= 1'b0;
               release_reg <= 1'b0;
               repeat_reg  <= 1'b0;
               state_reg   <= IDLE;
               rcnt_reg    <= '0;
            end else begin
               dcnt_reg    <= dcnt_next;
               level_reg   <= level_next;
               press_reg   <= press_next;
               release_reg <= release_next;
               repeat_reg  <= repeat_next;
               state_reg   <= state_next;
               rcnt_reg    <= rcnt_next;
            end
         end

         assign key_level[gi]   = level_reg;
         assign key_press[gi]   = press_reg;
         assign key_release[gi] = release_reg;
         assign key_repeat[gi]  = repeat_reg;
      end
   endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random key activity,
// compared every cycle against a window/elapsed-time reference model.
module tb_key_conditioner;

   localparam int DEB = 8;
   localparam int RD  = 20;
   localparam int RP  = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] Key = 4'hF;
   logic [3:0] key_level, key_press, key_release, key_repeat;

   key_conditioner #(
      .N_KEYS(4), .DEBOUNCE_CYC(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(26)
   ) dut (
      .clk(clk), .reset(reset), .Key(Key),
      .key_level(key_level), .key_press(key_press),
      .key_release(key_release), .key_repeat(key_repeat)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Model: raw keys delayed two cycles, last DEB pressed-samples, press timestamps.
   logic [3:0] kq[$];
   logic [3:0] sh[$];
   logic [3:0] m_level, m_press, m_release, m_repeat;
   int         press_t[4];

   task automatic check4(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      kq.delete();
      kq.push_back(4'hF);
      kq.push_back(4'hF);
      sh.delete();
      m_level = '0; m_press = '0; m_release = '0; m_repeat = '0;
   endtask

   task automatic model_edge();
      logic [3:0] old;
      bit         all_diff;
      int         held;
      old = kq.pop_front();
      kq.push_back(Key);
      sh.push_back(~old);
      if (sh.size() > DEB) sh.delete(0);
      m_press = '0; m_release = '0; m_repeat = '0;
      for (int k = 0; k < 4; k++) begin
         all_diff = (sh.size() == DEB);
         foreach (sh[i]) if (sh[i][k] == m_level[k]) all_diff = 0;
         if (all_diff) begin
            m_level[k] = ~m_level[k];
            if (m_level[k]) begin
               m_press[k] = 1'b1;
               press_t[k] = cyc;
            end else begin
               m_release[k] = 1'b1;
            end
         end else if (m_level[k]) begin
            held = cyc - press_t[k];
            if (held >= RD && (held - RD) % RP == 0) m_repeat[k] = 1'b1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      if (!reset) model_reset();
      else model_edge();
      #1;
      check4("level",   key_level,   m_level);
      check4("press",   key_press,   m_press);
      check4("release", key_release, m_release);
      check4("repeat",  key_repeat,  m_repeat);
   endtask

   task automatic async_reset();
      reset = 1'b0;
      model_reset();
      #1;
      check4("rst_level",  key_level,  4'h0);
      check4("rst_repeat", key_repeat, 4'h0);
      check4("rst_press",  key_press,  4'h0);
   endtask

   initial begin
      int npress;
      int nrep;
      int k;
      model_reset();
      for (int i = 0; i < 4; i++) press_t[i] = 0;

      // Reset with all keys held, then release reset.
      #2;
      Key = 4'h0;
      async_reset();
      repeat (3) tick();
      reset = 1'b1;
      repeat (9) tick();
      check4("lvl_before_10", key_level, 4'h0);
      tick();
      check4("lvl_at_10", key_level, 4'hF);
      check4("press_at_10", key_press, 4'hF);
      tick();
      check4("press_width", key_press, 4'h0);
      Key = 4'hF;
      repeat (12) tick();
      $display("phase reset_release cyc=%0d", cyc);

      // Bounce on key 0.
      npress = 0;
      Key = 4'hE;
      repeat (5) begin tick(); if (key_press[0]) npress++; end
      Key = 4'hF;
      tick(); if (key_press[0]) npress++;
      Key = 4'hE;
      repeat (9) begin tick(); if (key_press[0]) npress++; end
      check4("bounce_no_early", {3'b000, key_press[0]}, 4'h0);
      tick();
      check4("bounce_press_10", key_press, 4'h1);
      npress += int'(key_press[0]);
      repeat (10) begin tick(); if (key_press[0]) npress++; end
      check4("bounce_one_press", 4'(npress), 4'd1);
      Key = 4'hF;
      repeat (12) tick();
      $display("phase bounce cyc=%0d", cyc);

      // Clean press/release on key 1.
      Key = 4'hD;
      repeat (15) tick();
      Key = 4'hF;
      repeat (9) tick();
      check4("rel_not_yet", key_release, 4'h0);
      tick();
      check4("rel_at_10", key_release, 4'h2);
      check4("rel_level", key_level, 4'h0);
      repeat (4) tick();
      $display("phase release cyc=%0d", cyc);

      // Repeat on key 2, release lands exactly on a repeat expiry.
      Key = 4'hB;
      repeat (10) tick();
      check4("rpt_press", key_press, 4'h4);
      check4("rpt_none_on_press", key_repeat, 4'h0);
      nrep = 0;
      repeat (65) begin tick(); if (key_repeat[2]) nrep++; end
      check4("rpt_count", 4'(nrep), 4'd10);
      Key = 4'hF;
      repeat (9) tick();
      tick();
      check4("rpt_rel_pulse", key_release, 4'h4);
      check4("rpt_suppressed", key_repeat, 4'h0);
      repeat (12) tick();
      $display("phase repeat cyc=%0d reps=%0d", cyc, nrep);

      // Simultaneous press on keys 3 and 0, then async reset mid-delay.
      Key = 4'b0110;
      repeat (9) tick();
      tick();
      check4("simul_press", key_press, 4'b1001);
      repeat (8) tick();
      async_reset();
      repeat (3) tick();
      reset = 1'b1;
      repeat (9) tick();
      check4("rearm_not_yet", key_level, 4'h0);
      tick();
      check4("rearm_press", key_press, 4'b1001);
      repeat (30) tick();
      Key = 4'hF;
      repeat (15) tick();
      $display("phase independence cyc=%0d", cyc);

      // Random key activity with occasional async resets.
      for (int n = 0; n < 45; n++) begin
         k = int'($urandom_range(0, 3));
         Key[k] = ~Key[k];
         if ($urandom_range(0, 14) == 0) begin
            async_reset();
            tick();
            reset = 1'b1;
         end
         repeat ($urandom_range(1, 40)) tick();
      end
      Key = 4'hF;
      repeat (15) tick();
      $display("phase random cyc=%0d", cyc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
